// File: rtl/sram_param.sv
// Single-port byte-writable SRAM with a self-clearing sweep after reset and a
// configurable 1- or 2-cycle registered read path with out-of-range flagging.
module sram_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic                busy,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_rvalid;
  logic              r_err;

  logic              w_acc;
  logic              w_rd;
  logic              w_oor;
  logic              w_wr_ok;
  logic              w_wr_err;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_mem_q;
  logic              w_fin_v;
  logic              w_fin_oor;
  logic [DATA_W-1:0] w_fin_d;

  assign busy     = (r_state == S_INIT);
  assign w_acc    = en && (r_state == S_RUN);
  assign w_rd     = w_acc && !we;
  assign w_oor    = ({1'b0, addr} >= DEPTH_A);
  assign w_wr_ok  = w_acc && we && !w_oor;
  assign w_wr_err = w_acc && we && w_oor;
  assign w_idx    = addr[IDX_W-1:0];
  assign w_mem_q  = w_oor ? '0 : r_mem[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else if (r_state == S_INIT) begin
      if (r_ptr == LAST_IDX) begin
        r_state <= S_RUN;
        r_ptr   <= '0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  // Array has no reset of its own; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (be[i]) r_mem[w_idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // Data is captured at the accept edge in both variants, so later writes
  // cannot disturb a read that is already in flight.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_s1_v;
      logic              r_s1_oor;
      logic [DATA_W-1:0] r_s1_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_v   <= 1'b0;
          r_s1_oor <= 1'b0;
          r_s1_d   <= '0;
        end else begin
          r_s1_v   <= w_rd;
          r_s1_oor <= w_oor;
          if (w_rd) r_s1_d <= w_mem_q;
        end
      end

      assign w_fin_v   = r_s1_v;
      assign w_fin_oor = r_s1_oor;
      assign w_fin_d   = r_s1_d;
    end else begin : g_lat1
      assign w_fin_v   = w_rd;
      assign w_fin_oor = w_oor;
      assign w_fin_d   = w_mem_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_fin_v;
      r_err    <= (w_fin_v && w_fin_oor) || w_wr_err;
      if (w_fin_v) r_dout <= w_fin_d;
    end
  end

  assign dout   = r_dout;
  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule

// File: tb/tb_sram_param.sv
// Directed bench for sram_param: one RD_LAT=1 and one RD_LAT=2 instance share
// every input, so both see identical traffic.
module tb_sram_param;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [3:0]  be;

  logic        busy1, rvalid1, err1;
  logic [31:0] dout1;
  logic        busy2, rvalid2, err2;
  logic [31:0] dout2;

  int n_checks = 0;
  int n_errors = 0;

  sram_param #(.DATA_W(32), .DEPTH(32), .ADDR_W(10), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din), .be(be),
    .busy(busy1), .dout(dout1), .rvalid(rvalid1), .err(err1)
  );

  sram_param #(.DATA_W(32), .DEPTH(32), .ADDR_W(10), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din), .be(be),
    .busy(busy2), .dout(dout2), .rvalid(rvalid2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    en = 1'b1; we = 1'b1; addr = a; din = d; be = b;
    tick();
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    en = 1'b1; we = 1'b0; addr = a;
    tick();
    en = 1'b0;
  endtask

  // Counts edges until busy drops; any rvalid/err seen meanwhile sets flag.
  task automatic wait_init(output int cnt, output logic flag);
    cnt  = 0;
    flag = 1'b0;
    while (busy1 && cnt < 100) begin
      tick();
      cnt++;
      if (rvalid1 || err1 || rvalid2 || err2) flag = 1'b1;
      if (busy1 !== busy2) flag = 1'b1;
    end
  endtask

  int   cnt;
  logic flag;

  initial begin
    rst_n = 1'b0; en = 1'b1; we = 1'b0; addr = '0; din = '0; be = '0;
    tick();
    tick();
    check("rst_state", {busy1, rvalid1, err1, dout1}, {1'b1, 1'b0, 1'b0, 32'h0});
    check("rst_state2", {busy2, rvalid2, err2, dout2}, {1'b1, 1'b0, 1'b0, 32'h0});

    rst_n = 1'b1;
    wait_init(cnt, flag);
    en = 1'b0;
    check("init_cycles", 64'(cnt), 64'd32);
    check("init_quiet", 64'(flag), 64'd0);

    for (int i = 0; i < 32; i++) begin
      rd(10'(i));
      check($sformatf("sweep_%0d", i), {rvalid1, err1, dout1}, {1'b1, 1'b0, 32'h0});
    end
    tick();
    check("rvalid_pulse", 64'(rvalid1), 64'd0);

    wr(10'd3, 32'hA5A5A5A5, 4'hF);
    check("wr_no_rvalid", {rvalid1, err1, dout1}, {1'b0, 1'b0, 32'h0});
    wr(10'd3, 32'h11223344, 4'b0101);
    rd(10'd3);
    check("byte_en", {rvalid1, dout1}, {1'b1, 32'hA522A544});
    wr(10'd3, 32'hFFFFFFFF, 4'h0);
    check("be0_hold", {rvalid1, err1, dout1}, {1'b0, 1'b0, 32'hA522A544});
    rd(10'd3);
    check("be0_data", dout1, 32'hA522A544);

    for (int i = 0; i < 4; i++) wr(10'(i), 32'(i), 4'hF);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        en = 1'b1; we = 1'b0; addr = 10'(k);
      end else begin
        en = 1'b0;
      end
      tick();
      check($sformatf("lat2_v_%0d", k), 64'(rvalid2), 64'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) check($sformatf("lat2_d_%0d", k), dout2, 32'(k - 1));
      check($sformatf("lat1_v_%0d", k), 64'(rvalid1), 64'(k <= 3));
      if (k <= 3) check($sformatf("lat1_d_%0d", k), dout1, 32'(k));
    end

    wr(10'd8, 32'h12345678, 4'hF);
    rd(10'd40);
    check("oor_rd", {rvalid1, err1, dout1}, {1'b1, 1'b1, 32'h0});
    check("oor_rd2_early", 64'(err2), 64'd0);
    tick();
    check("oor_rd2", {rvalid2, err2, dout2}, {1'b1, 1'b1, 32'h0});
    check("oor_err_pulse", 64'(err1), 64'd0);
    wr(10'd40, 32'hFFFFFFFF, 4'hF);
    check("oor_wr", {rvalid1, err1}, {1'b0, 1'b1});
    tick();
    check("oor_wr_pulse", 64'(err1), 64'd0);
    rd(10'd8);
    check("oor_alias", {err1, dout1}, {1'b0, 32'h12345678});

    wr(10'd5, 32'hDEADBEEF, 4'hF);
    rd(10'd5);
    check("raw_next", dout1, 32'hDEADBEEF);
    en = 1'b1; we = 1'b0; addr = 10'd5;
    tick();
    we = 1'b1; din = 32'hCAFEF00D; be = 4'hF;
    tick();
    en = 1'b0; we = 1'b0;
    check("inflight_old", {rvalid2, dout2}, {1'b1, 32'hDEADBEEF});
    rd(10'd5);
    check("inflight_new", dout1, 32'hCAFEF00D);

    en = 1'b1; we = 1'b0; addr = 10'd5;
    tick();
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrd_rst", {busy2, rvalid2, err2, dout2}, {1'b1, 1'b0, 1'b0, 32'h0});
    check("midrd_rst1", {busy1, rvalid1, dout1}, {1'b1, 1'b0, 32'h0});
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("reinit_busy", 64'(busy1), 64'd1);
    tick();
    rst_n = 1'b1;
    wait_init(cnt, flag);
    check("reinit_cycles", 64'(cnt), 64'd32);
    check("reinit_quiet", 64'(flag), 64'd0);
    rd(10'd5);
    check("cleared_5", {rvalid1, dout1}, {1'b1, 32'h0});
    rd(10'd3);
    check("cleared_3", dout1, 32'h0);
    rd(10'd0);
    check("cleared_0", dout1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
